// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read misses stall the core while a 128-bit line is refilled from memory.
module dcache_ctrl #(
  parameter int INDEX_BITS  = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [9:0]   cpu_address,
  input  logic         cpu_read,
  input  logic         cpu_write,
  input  logic [31:0]  cpu_write_data,
  output logic [31:0]  cpu_read_data,
  output logic         stall,
  output logic [9:0]   mem_address,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_write_data,
  input  logic [127:0] mem_read_data,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int NUM_LINES = 2 ** INDEX_BITS;
  localparam int TAG_BITS  = 8 - INDEX_BITS;
  localparam int CW        = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                state;
  state_t                next_state;
  logic [CW-1:0]         count;
  logic [NUM_LINES-1:0]  valid;
  logic [TAG_BITS-1:0]   tags  [NUM_LINES];
  logic [127:0]          lines [NUM_LINES];
  logic [31:0]           last_data;

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [31:0]           hit_word;
  logic                  hit;
  logic                  read_hit;
  logic                  read_miss;
  logic                  write_hit;
  logic                  fill;

  assign offset   = cpu_address[1:0];
  assign idx      = cpu_address[INDEX_BITS+1:2];
  assign tag      = cpu_address[9:INDEX_BITS+2];
  assign hit_word = lines[idx][{offset, 5'b00000} +: 32];

  // All strobes are gated by reset so nothing leaks out while it is held low.
  always_comb begin
    next_state     = state;
    stall          = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    hit            = valid[idx] && (tags[idx] == tag);
    read_hit       = 1'b0;
    read_miss      = 1'b0;
    write_hit      = 1'b0;
    fill           = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (cpu_write) begin
            mem_write      = 1'b1;
            mem_address    = cpu_address;
            mem_write_data = cpu_write_data;
            write_hit      = hit;
          end else if (cpu_read) begin
            if (hit) begin
              read_hit = 1'b1;
            end else begin
              read_miss  = 1'b1;
              stall      = 1'b1;
              next_state = REFILL;
            end
          end
        end
        REFILL: begin
          stall       = 1'b1;
          mem_read    = 1'b1;
          mem_address = {tag, idx, 2'b00};
          if (count == '0) begin
            fill       = 1'b1;
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
    cpu_read_data = read_hit ? hit_word : last_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      valid      <= '0;
      last_data  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= next_state;
      if (read_miss)
        count <= CW'(MEM_LATENCY - 1);
      else if (state == REFILL && count != '0)
        count <= count - 1'b1;
      if (read_hit) begin
        last_data <= hit_word;
        if (hit_count != 16'hFFFF)
          hit_count <= hit_count + 16'd1;
      end
      if (read_miss && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
      if (fill)
        valid[idx] <= 1'b1;
    end
  end

  // Line data and tags are deliberately not reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill) begin
      lines[idx] <= mem_read_data;
      tags[idx]  <= tag;
    end else if (write_hit) begin
      lines[idx][{offset, 5'b00000} +: 32] <= cpu_write_data;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: one instance with MEM_LATENCY=1 and one with 3,
// each backed by a behavioural line memory.
module tb_dcache_ctrl;

  logic         clk;
  logic         reset, reset_3;
  logic [9:0]   cpu_address, cpu_address_3;
  logic         cpu_read, cpu_read_3, cpu_write, cpu_write_3;
  logic [31:0]  cpu_write_data, cpu_write_data_3;
  logic [31:0]  cpu_read_data, cpu_read_data_3;
  logic         stall, stall_3;
  logic [9:0]   mem_address, mem_address_3;
  logic         mem_read, mem_read_3, mem_write, mem_write_3;
  logic [31:0]  mem_write_data, mem_write_data_3;
  logic [127:0] mem_read_data, mem_read_data_3;
  logic [15:0]  hit_count, hit_count_3, miss_count, miss_count_3;
  logic [127:0] mem [256];

  int compared   = 0;
  int mismatched = 0;

  dcache_ctrl #(.INDEX_BITS(4), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .cpu_address(cpu_address), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
    .stall(stall), .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .hit_count(hit_count), .miss_count(miss_count));

  dcache_ctrl #(.INDEX_BITS(4), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset_3), .cpu_address(cpu_address_3), .cpu_read(cpu_read_3),
    .cpu_write(cpu_write_3), .cpu_write_data(cpu_write_data_3), .cpu_read_data(cpu_read_data_3),
    .stall(stall_3), .mem_address(mem_address_3), .mem_read(mem_read_3), .mem_write(mem_write_3),
    .mem_write_data(mem_write_data_3), .mem_read_data(mem_read_data_3),
    .hit_count(hit_count_3), .miss_count(miss_count_3));

  // Word k of line l holds 32'hC0DE0000 + 16*l + k.
  function automatic logic [127:0] line_pattern(input int l);
    logic [127:0] v;
    for (int k = 0; k < 4; k++) v[32*k +: 32] = 32'hC0DE0000 + 32'(l * 16 + k);
    return v;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= line_pattern(i);
    end else if (mem_write) begin
      mem[mem_address[9:2]][{mem_address[1:0], 5'b00000} +: 32] <= mem_write_data;
    end
  end

  assign mem_read_data = mem[mem_address[9:2]];

  always_comb mem_read_data_3 = line_pattern(int'(mem_address_3[9:2]));

  task automatic test_reset;
    reset = 1'b0; reset_3 = 1'b0;
    cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_write_data = '0;
    cpu_address_3 = '0; cpu_read_3 = 1'b0; cpu_write_3 = 1'b0; cpu_write_data_3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
    compared++; if (mem_read !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_read: got %b want 0", mem_read); end
    compared++; if (mem_write !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_write: got %b want 0", mem_write); end
    compared++; if (mem_address !== 10'h000) begin mismatched++; $display("[TB] FAIL reset_mem_address: got %h want 000", mem_address); end
    compared++; if (mem_write_data !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_mem_write_data: got %h want 0", mem_write_data); end
    compared++; if (cpu_read_data !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_read_data: got %h want 0", cpu_read_data); end
    compared++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_counters: got %h/%h want 0/0", hit_count, miss_count); end
    compared++; if (stall_3 !== 1'b0 || mem_read_3 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dut3: got stall %b mem_read %b want 0 0", stall_3, mem_read_3); end
    @(posedge clk); #1;
    reset = 1'b1; reset_3 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_miss;
    cpu_read = 1'b1; cpu_address = 10'h004;
    @(negedge clk);
    compared++; if (stall !== 1'b1 || mem_read !== 1'b0) begin mismatched++; $display("[TB] FAIL miss_cycle0: got stall %b mem_read %b want 1 0", stall, mem_read); end
    @(posedge clk); @(negedge clk);
    compared++; if (stall !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0) begin mismatched++; $display("[TB] FAIL miss_refill: got stall %b mem_read %b mem_write %b want 1 1 0", stall, mem_read, mem_write); end
    compared++; if (mem_address !== 10'h004) begin mismatched++; $display("[TB] FAIL miss_refill_addr: got %h want 004", mem_address); end
    @(posedge clk); @(negedge clk);
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL miss_done_stall: got %b want 0", stall); end
    compared++; if (cpu_read_data !== 32'hC0DE0010) begin mismatched++; $display("[TB] FAIL miss_done_data: got %h want C0DE0010", cpu_read_data); end
    compared++; if (miss_count !== 16'd1) begin mismatched++; $display("[TB] FAIL miss_count_1: got %0d want 1", miss_count); end
    @(posedge clk); #1;
    compared++; if (hit_count !== 16'd1) begin mismatched++; $display("[TB] FAIL hit_count_1: got %0d want 1", hit_count); end
  endtask

  task automatic test_read_hit;
    cpu_address = 10'h006;
    @(negedge clk);
    compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL hit_stall: got %b want 0", stall); end
    compared++; if (cpu_read_data !== 32'hC0DE0012) begin mismatched++; $display("[TB] FAIL hit_data: got %h want C0DE0012", cpu_read_data); end
    @(posedge clk); #1;
    compared++; if (hit_count !== 16'd2) begin mismatched++; $display("[TB] FAIL hit_count_2: got %0d want 2", hit_count); end
  endtask

  task automatic test_write_hit;
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_address = 10'h005; cpu_write_data = 32'hDEADBEEF;
    @(negedge clk);
    compared++; if (mem_write !== 1'b1 || stall !== 1'b0 || mem_read !== 1'b0) begin mismatched++; $display("[TB] FAIL write_strobes: got mem_write %b stall %b mem_read %b want 1 0 0", mem_write, stall, mem_read); end
    compared++; if (mem_address !== 10'h005 || mem_write_data !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL write_bus: got %h/%h want 005/DEADBEEF", mem_address, mem_write_data); end
    @(posedge clk); #1;
    cpu_write = 1'b0; cpu_read = 1'b1;
    @(negedge clk);
    compared++; if (mem_write !== 1'b0 || stall !== 1'b0) begin mismatched++; $display("[TB] FAIL write_then_read: got mem_write %b stall %b want 0 0", mem_write, stall); end
    compared++; if (cpu_read_data !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL write_hit_data: got %h want DEADBEEF", cpu_read_data); end
    @(posedge clk); #1;
    compared++; if (hit_count !== 16'd3 || miss_count !== 16'd1) begin mismatched++; $display("[TB] FAIL write_counters: got %0d/%0d want 3/1", hit_count, miss_count); end
    cpu_read = 1'b0; cpu_address = 10'h3F0;
    @(negedge clk);
    compared++; if (stall !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_strobes: got %b%b%b want 000", stall, mem_read, mem_write); end
    compared++; if (cpu_read_data !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL idle_hold_data: got %h want DEADBEEF", cpu_read_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_conflict;
    cpu_read = 1'b1; cpu_address = 10'h004;
    @(negedge clk);
    compared++; if (stall !== 1'b0 || cpu_read_data !== 32'hC0DE0010) begin mismatched++; $display("[TB] FAIL conflict_first: got stall %b data %h want 0 C0DE0010", stall, cpu_read_data); end
    @(posedge clk); #1;
    cpu_address = 10'h044;
    @(negedge clk);
    compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL conflict_miss: got stall %b want 1", stall); end
    @(posedge clk); @(negedge clk);
    compared++; if (mem_address !== 10'h044 || mem_read !== 1'b1) begin mismatched++; $display("[TB] FAIL conflict_refill: got %h/%b want 044/1", mem_address, mem_read); end
    @(posedge clk); @(negedge clk);
    compared++; if (stall !== 1'b0 || cpu_read_data !== 32'hC0DE0110) begin mismatched++; $display("[TB] FAIL conflict_data: got stall %b data %h want 0 C0DE0110", stall, cpu_read_data); end
    @(posedge clk); #1;
    cpu_address = 10'h004;
    @(negedge clk);
    compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL conflict_evicted: got stall %b want 1", stall); end
    @(posedge clk); @(negedge clk);
    compared++; if (mem_address !== 10'h004) begin mismatched++; $display("[TB] FAIL conflict_refill2: got %h want 004", mem_address); end
    @(posedge clk); @(negedge clk);
    compared++; if (cpu_read_data !== 32'hC0DE0010 || miss_count !== 16'd3) begin mismatched++; $display("[TB] FAIL conflict_miss3: got data %h miss %0d want C0DE0010 3", cpu_read_data, miss_count); end
    @(posedge clk); #1;
    cpu_address = 10'h005;
    @(negedge clk);
    compared++; if (stall !== 1'b0 || cpu_read_data !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL write_through: got stall %b data %h want 0 DEADBEEF", stall, cpu_read_data); end
    @(posedge clk); #1;
    compared++; if (hit_count !== 16'd7) begin mismatched++; $display("[TB] FAIL hit_count_7: got %0d want 7", hit_count); end
  endtask

  task automatic test_saturation;
    cpu_read = 1'b1; cpu_address = 10'h004;
    repeat (16'hFFFE - 7) @(posedge clk);
    #1;
    compared++; if (hit_count !== 16'hFFFE) begin mismatched++; $display("[TB] FAIL sat_preload: got %h want FFFE", hit_count); end
    @(posedge clk); #1;
    compared++; if (hit_count !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL sat_reach: got %h want FFFF", hit_count); end
    repeat (2) @(posedge clk);
    #1;
    compared++; if (hit_count !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL sat_hold: got %h want FFFF", hit_count); end
    compared++; if (miss_count !== 16'd3) begin mismatched++; $display("[TB] FAIL sat_miss_count: got %0d want 3", miss_count); end
    cpu_read = 1'b0;
  endtask

  task automatic test_latency3;
    int stall_cycles = 0;
    int mread_cycles = 0;
    cpu_read_3 = 1'b1; cpu_address_3 = 10'h008;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (stall_3) stall_cycles++;
      if (mem_read_3) mread_cycles++;
      @(posedge clk);
    end
    #1;
    compared++; if (stall_cycles != 4) begin mismatched++; $display("[TB] FAIL lat3_stall_cycles: got %0d want 4", stall_cycles); end
    compared++; if (mread_cycles != 3) begin mismatched++; $display("[TB] FAIL lat3_mem_read_cycles: got %0d want 3", mread_cycles); end
    compared++; if (cpu_read_data_3 !== 32'hC0DE0020) begin mismatched++; $display("[TB] FAIL lat3_data: got %h want C0DE0020", cpu_read_data_3); end
    compared++; if (hit_count_3 !== 16'd4 || miss_count_3 !== 16'd1) begin mismatched++; $display("[TB] FAIL lat3_counters: got %0d/%0d want 4/1", hit_count_3, miss_count_3); end
  endtask

  task automatic test_reset_mid_refill;
    bit done = 1'b0;
    cpu_address_3 = 10'h048;
    @(negedge clk);
    compared++; if (stall_3 !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_miss: got stall %b want 1", stall_3); end
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    compared++; if (mem_read_3 !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_refilling: got mem_read %b want 1", mem_read_3); end
    #1 reset_3 = 1'b0;
    #1;
    compared++; if (stall_3 !== 1'b0 || mem_read_3 !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_drop: got stall %b mem_read %b want 0 0", stall_3, mem_read_3); end
    compared++; if (miss_count_3 !== 16'd0 || hit_count_3 !== 16'd0) begin mismatched++; $display("[TB] FAIL midrst_counters: got %0d/%0d want 0/0", hit_count_3, miss_count_3); end
    @(posedge clk); #1;
    reset_3 = 1'b1;
    @(negedge clk);
    compared++; if (stall_3 !== 1'b1 || mem_read_3 !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_remiss: got stall %b mem_read %b want 1 0", stall_3, mem_read_3); end
    for (int i = 0; i < 10 && !done; i++) begin
      @(posedge clk); @(negedge clk);
      if (!stall_3) done = 1'b1;
    end
    compared++; if (!done) begin mismatched++; $display("[TB] FAIL midrst_timeout: got stall still 1 want refill to finish"); end
    compared++; if (cpu_read_data_3 !== 32'hC0DE0120 || miss_count_3 !== 16'd1) begin mismatched++; $display("[TB] FAIL midrst_refill: got data %h miss %0d want C0DE0120 1", cpu_read_data_3, miss_count_3); end
    cpu_read_3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_conflict();
    test_saturation();
    test_latency3();
    test_reset_mid_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
